// File: rtl/boot_pkg.sv
// Shared definitions for the instruction boot loader: loader states,
// stream field widths and the header acceptance rule.
package boot_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HDR_W  = 16;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA,
    RUN,
    DONE,
    ERR
  } boot_state_e;

  // A word count is loadable when it is non-zero and fits the memory.
  function automatic logic hdr_count_ok(input logic [HDR_W-1:0] n,
                                        input int unsigned depth_log2);
    return (n != '0) && (32'(n) <= (32'd1 << depth_log2));
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes big-endian into 32-bit words; word_done_o
// pulses combinationally alongside the fourth byte of each word.
module word_assembler
  import boot_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              take_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              word_done_o,
  output logic [WORD_W-1:0] word_o
);

  logic [1:0]               cnt_q;
  logic [WORD_W-BYTE_W-1:0] shift_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (take_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_i};
    end
  end

  assign word_done_o = take_i && (cnt_q == 2'd3);
  assign word_o      = {shift_q, byte_i};

endmodule

// File: rtl/instr_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream into instruction
// memory, then releases the CPU for a fixed run window and freezes it.
module instr_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 8,
  parameter int unsigned RUN_CYCLES = 100
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  byte_valid_i,
  input  logic [BYTE_W-1:0]     byte_data_i,
  output logic                  byte_ready_o,
  output logic                  im_we_o,
  output logic [DEPTH_LOG2-1:0] im_addr_o,
  output logic [WORD_W-1:0]     im_wdata_o,
  output logic                  cpu_rst_n_o,
  output logic                  cpu_run_o,
  output logic                  run_done_o,
  output logic                  err_o
);

  localparam int unsigned RC_W = (RUN_CYCLES > 0) ? $clog2(RUN_CYCLES + 1) : 1;

  boot_state_e           state_q, state_d;
  logic [BYTE_W-1:0]     hdr_hi_q;
  logic [HDR_W-1:0]      n_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [RC_W-1:0]       run_cnt_q;
  logic                  byte_ready_q, im_we_q, cpu_rst_n_q, cpu_run_q;
  logic                  run_done_q, err_q;
  logic [DEPTH_LOG2-1:0] im_addr_q;
  logic [WORD_W-1:0]     im_wdata_q;

  logic              fire, take, word_done, last_word, run_expired;
  logic [WORD_W-1:0] word;
  logic [HDR_W-1:0]  hdr_n;

  assign fire        = byte_valid_i && byte_ready_q;
  assign take        = fire && (state_q == DATA);
  assign hdr_n       = {hdr_hi_q, byte_data_i};
  assign last_word   = (32'(idx_q) + 32'd1) == 32'(n_q);
  assign run_expired = (run_cnt_q == RC_W'(RUN_CYCLES));

  word_assembler u_asm (
    .clk_i       (clk_i),
    .rst_ni      (rst_i),
    .take_i      (take),
    .byte_i      (byte_data_i),
    .word_done_o (word_done),
    .word_o      (word)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_HI: if (fire) state_d = HDR_LO;
      HDR_LO: if (fire) state_d = hdr_count_ok(hdr_n, DEPTH_LOG2) ? DATA : ERR;
      DATA:   if (word_done && last_word) state_d = RUN;
      RUN:    if (run_expired) state_d = DONE;
      DONE:   state_d = DONE;
      ERR:    state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // Outputs are registered from the next state so they track the state
  // register exactly; the CPU controls lag by one cycle behind entering RUN.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= HDR_HI;
      hdr_hi_q     <= '0;
      n_q          <= '0;
      idx_q        <= '0;
      run_cnt_q    <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_run_q    <= 1'b0;
      run_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_ready_q <= (state_d == HDR_HI) || (state_d == HDR_LO) || (state_d == DATA);
      err_q        <= (state_d == ERR);
      run_done_q   <= (state_d == DONE);
      cpu_rst_n_q  <= (state_q == RUN) || (state_q == DONE);
      cpu_run_q    <= (state_q == RUN) && !run_expired;
      im_we_q      <= word_done;

      if (fire && (state_q == HDR_HI)) hdr_hi_q <= byte_data_i;
      if (fire && (state_q == HDR_LO)) n_q <= hdr_n;

      if (word_done) begin
        im_wdata_q <= word;
        im_addr_q  <= idx_q;
        if (!last_word) idx_q <= idx_q + 1'b1;
      end

      if ((state_q == RUN) && !run_expired) run_cnt_q <= run_cnt_q + 1'b1;
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign im_we_o      = im_we_q;
  assign im_addr_o    = im_addr_q;
  assign im_wdata_o   = im_wdata_q;
  assign cpu_rst_n_o  = cpu_rst_n_q;
  assign cpu_run_o    = cpu_run_q;
  assign run_done_o   = run_done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_instr_boot_loader.sv
// Scoreboard bench for instr_boot_loader: expected writes queued as words
// are issued, a negedge monitor checks every im_we_o pulse against them.
module tb_instr_boot_loader;

  localparam int unsigned DL = 8;
  localparam int unsigned RC = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bv = 1'b0;
  logic [7:0]    bd = '0;
  logic          byte_ready_o, im_we_o, cpu_rst_n_o, cpu_run_o, run_done_o, err_o;
  logic [DL-1:0] im_addr_o;
  logic [31:0]   im_wdata_o;

  instr_boot_loader #(.DEPTH_LOG2(DL), .RUN_CYCLES(RC)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .byte_valid_i (bv),
    .byte_data_i  (bd),
    .byte_ready_o (byte_ready_o),
    .im_we_o      (im_we_o),
    .im_addr_o    (im_addr_o),
    .im_wdata_o   (im_wdata_o),
    .cpu_rst_n_o  (cpu_rst_n_o),
    .cpu_run_o    (cpu_run_o),
    .run_done_o   (run_done_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] words_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n && im_we_o) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                 im_addr_o, im_wdata_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(im_addr_o), 64'(e.addr));
        chk("wr_data", 64'(im_wdata_o), 64'(e.data));
      end
    end
  end

  task automatic idle(input int unsigned n);
    bv = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    acc = 1'b0;
    bv  = 1'b1;
    bd  = b;
    for (int k = 0; k < 50; k++) begin
      acc = byte_ready_o;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    bv = 1'b0;
    if (!acc) chk("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bv    = 1'b0;
    #1;
    chk("rst_ready",  64'(byte_ready_o), 64'(0));
    chk("rst_we",     64'(im_we_o),      64'(0));
    chk("rst_addr",   64'(im_addr_o),    64'(0));
    chk("rst_wdata",  64'(im_wdata_o),   64'(0));
    chk("rst_cpurst", {cpu_rst_n_o, cpu_run_o, run_done_o, err_o}, 64'(0));
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 64'(byte_ready_o), 64'(1));
  endtask

  task automatic send_header(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  // Reference: word i lands at address i, built from its four bytes MSB first.
  task automatic load_words(input bit gaps);
    logic [31:0] w;
    wr_t         e;
    send_header(16'(words_q.size()));
    for (int i = 0; i < words_q.size(); i++) begin
      w      = words_q[i];
      e.addr = 32'(i);
      e.data = w;
      exp_q.push_back(e);
      for (int k = 3; k >= 0; k--) begin
        if (gaps) idle($urandom_range(0, 2));
        send_byte(8'((w >> (8 * k)) & 32'hFF));
        if (i == 0 && k == 3) chk("cpu_held_in_load", {cpu_rst_n_o, cpu_run_o}, 64'(0));
      end
    end
  endtask

  task automatic run_check();
    int unsigned len;
    chk("rstn_low_on_last_we", 64'(cpu_rst_n_o), 64'(0));
    chk("ready_low_in_run",    64'(byte_ready_o), 64'(0));
    @(posedge clk);
    #1;
    chk("rstn_rise", 64'(cpu_rst_n_o), 64'(1));
    len = 0;
    while (cpu_run_o && len < 300) begin
      len++;
      @(posedge clk);
      #1;
    end
    chk("run_len",       64'(len),         64'(RC));
    chk("run_done",      64'(run_done_o),  64'(1));
    chk("run_off",       64'(cpu_run_o),   64'(0));
    chk("rstn_in_done",  64'(cpu_rst_n_o), 64'(1));
    chk("err_in_done",   64'(err_o),       64'(0));
  endtask

  initial begin
    int wr_before;

    do_reset();

    // Three-word program, back-to-back bytes.
    words_q = '{32'h20010005, 32'h20020007, 32'h00221820};
    load_words(1'b0);
    run_check();

    // Stream held valid in DONE: nothing may be accepted or written.
    wr_before = n_writes;
    bv = 1'b1;
    bd = 8'hA5;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    chk("ready_in_done", 64'(byte_ready_o), 64'(0));
    chk("writes_in_done", 64'(n_writes - wr_before), 64'(0));
    bv = 1'b0;

    // Zero-length header.
    do_reset();
    send_header(16'h0000);
    chk("err_zero",       64'(err_o),        64'(1));
    chk("ready_err_zero", 64'(byte_ready_o), 64'(0));
    chk("cpu_err_zero",   {cpu_rst_n_o, cpu_run_o}, 64'(0));
    idle(5);

    // One word past capacity.
    do_reset();
    send_header(16'h0101);
    chk("err_over", 64'(err_o), 64'(1));

    // Exactly at capacity is accepted.
    do_reset();
    send_header(16'h0100);
    chk("err_cap",   64'(err_o),        64'(0));
    chk("ready_cap", 64'(byte_ready_o), 64'(1));

    // Single word with idle gaps between bytes.
    do_reset();
    words_q = '{32'hDEADBEEF};
    load_words(1'b1);
    run_check();

    // Reset after half of the second word, then reload.
    do_reset();
    words_q = '{32'hCAFEF00D};
    send_header(16'd2);
    begin
      wr_t e;
      e.addr = 32'd0;
      e.data = 32'hCAFEF00D;
      exp_q.push_back(e);
    end
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    send_byte(8'h11); send_byte(8'h22);
    do_reset();
    words_q = '{32'h12345678};
    load_words(1'b0);
    run_check();

    // Randomized programs.
    for (int it = 0; it < 3; it++) begin
      do_reset();
      words_q.delete();
      repeat ($urandom_range(1, 8)) words_q.push_back($urandom);
      load_words(1'b1);
      run_check();
    end

    idle(2);
    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_boot_loader.md
INSTR_BOOT_LOADER -- requirements
Module: instr_boot_loader

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning instruction-memory word-address width (capacity 2^DEPTH_LOG2 words).
REQ-002 SHALL have parameter RUN_CYCLES, default 100, meaning number of clocks the CPU runs after load.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port byte_valid_i  input  1  load-stream byte present.
REQ-006 SHALL have port byte_data_i  input  8  load-stream byte.
REQ-007 SHALL have port byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port im_we_o  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port im_addr_o  output  DEPTH_LOG2  instruction-memory word address.
REQ-010 SHALL have port im_wdata_o  output  32  instruction word.
REQ-011 SHALL have port cpu_rst_n_o  output  1  active-low reset driven to the CPU.
REQ-012 SHALL have port cpu_run_o  output  1  CPU clock enable.
REQ-013 SHALL have port run_done_o  output  1  run window complete; register file stable for dump.
REQ-014 SHALL have port err_o  output  1  malformed load stream.

Function
REQ-015 SHALL transfer a byte only on a rising edge with byte_valid_i and byte_ready_o both high; byte_valid_i while byte_ready_o is low is ignored.
REQ-016 SHALL implement states HDR_HI, HDR_LO, DATA, RUN, DONE, ERR; reset state HDR_HI.
REQ-017 SHALL interpret the first two accepted bytes as 16-bit word count N, big-endian (HDR_HI -> HDR_LO -> check).
REQ-018 SHALL enter ERR if N == 0 or N > 2^DEPTH_LOG2, else enter DATA.
REQ-019 SHALL in DATA assemble each four accepted bytes big-endian (first byte -> bits 31:24) into one word.
REQ-020 SHALL register the write: im_we_o high for exactly one cycle, the cycle after the fourth byte is accepted, with im_wdata_o the word and im_addr_o the word index (0 for the first, incrementing by 1).
REQ-021 SHALL hold byte_ready_o high throughout HDR_HI, HDR_LO, DATA, and low in RUN, DONE, ERR; no back-pressure is applied during the write cycle.
REQ-022 SHALL move DATA -> RUN on the same edge that issues the write of word N-1; cpu_rst_n_o and cpu_run_o rise in the cycle following the last im_we_o pulse.
REQ-023 SHALL hold cpu_rst_n_o low and cpu_run_o low in HDR_HI, HDR_LO, DATA, ERR.
REQ-024 SHALL in RUN keep cpu_rst_n_o and cpu_run_o high for exactly RUN_CYCLES cycles, counted by an internal counter of width clog2(RUN_CYCLES+1).
REQ-025 SHALL on expiry enter DONE: cpu_run_o low (CPU frozen, state preserved), cpu_rst_n_o high, run_done_o high; DONE and ERR are terminal until reset.
REQ-026 SHALL drive err_o high only in ERR.
REQ-027 SHALL never write an address >= N; the word index SHALL NOT wrap.

Reset
REQ-028 SHALL on rst_i low immediately force: state HDR_HI, byte_ready_o 0, im_we_o 0, im_addr_o 0, im_wdata_o 0, cpu_rst_n_o 0, cpu_run_o 0, run_done_o 0, err_o 0, all counters and partial-word bytes cleared.
REQ-029 SHALL drive byte_ready_o high from the first rising edge after rst_i deasserts.
REQ-030 SHALL, on reset mid-load or mid-run, discard partial words and restart at HDR_HI; instruction-memory contents are not cleared.

Structure
REQ-031 SHALL take state encoding, header width (16) and word width (32) from shared package boot_pkg.
REQ-032 SHALL place byte-to-word assembly (byte counter 0..3, shift register, word_done pulse) in sub-module word_assembler.

Verification
REQ-033 Load N=3, words 0x20010005, 0x20020007, 0x00221820 -> im_we_o pulses at addr 0,1,2 with those values; cpu_rst_n_o rises next cycle.
REQ-034 RUN_CYCLES=100 after load -> cpu_run_o high exactly 100 cycles, then run_done_o=1, cpu_run_o=0.
REQ-035 Header 0x0000 -> err_o=1, byte_ready_o=0, no im_we_o; header 0x0101 with DEPTH_LOG2=8 -> err_o=1.
REQ-036 byte_valid_i toggled with idle gaps mid-word, N=1, word 0xDEADBEEF -> single write of 0xDEADBEEF at addr 0.
REQ-037 rst_i pulled low after 2 of 4 bytes of word 1, then reload N=1 word 0x12345678 -> single write 0x12345678 at addr 0.
REQ-038 byte_valid_i held high in DONE -> no further bytes accepted, no im_we_o.
